pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register for the pipelined core, the generic successor to the fixed per-boundary stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a packed payload of `WIDTH` bits between two stages with a valid/ready handshake, downstream back-pressure (stall), and a flush that inserts an all-zero bubble. An optional skid slot breaks the combinational ready path so `in_ready` is driven from a flop.

## Interface
- `WIDTH`, default `` `DataBusBits ``: payload width in bits. Legal range is 1..512.
- `SKID`, default 1: selects the ready path. 1 gives a registered `in_ready` with a 2-entry skid. 0 gives a single register with combinational ready.
- `clk`  in  1: the only clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `flush`  in  1: discard every held and incoming entry this cycle.
- `in_valid`  in  1: the upstream stage presents `in_data`.
- `in_ready`  out  1: the block accepts `in_data` when `in_valid & in_ready` is high.
- `in_data`  in  WIDTH: payload from upstream.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: the downstream stage consumes the entry when `out_valid & out_ready` is high.
- `out_data`  out  WIDTH: payload to downstream. It reads zero whenever `out_valid=0`.

## Operation
- Storage:
  - Main register `m_data`/`m_valid` drives `out_data`/`out_valid` directly.
  - When `SKID=1`, a second register `s_data`/`s_valid` exists.
- Reset (`reset=1`):
  - All valid bits clear to 0 and all data registers clear to 0.
  - `out_valid=0`, `out_data=0`.
  - `in_ready=1` for `SKID=1`. For `SKID=0`, `in_ready` is combinational and evaluates to 1.
  - Reset has priority over `flush` and over every handshake.
- Flush (`flush=1`, `reset=0`):
  - Same end state as reset: all valid bits 0, all data 0.
  - An input handshake in the same cycle is discarded.
  - `in_ready` is not gated by `flush`.
- `SKID=1`, states are derived from (`m_valid`, `s_valid`):
  - EMPTY (0,0): `in_ready=1`. On accept, go to FULL with the payload in main.
  - FULL (1,0): `in_ready=1`.
    - Accept and pop: main is reloaded with `in_data` and the state stays FULL.
    - Pop only: go to EMPTY.
    - Accept without pop: write `in_data` to skid and go to SKID.
    - Neither: hold.
  - SKID (1,1): `in_ready=0`.
    - Pop: move skid to main, clear skid, go to FULL.
    - No pop: hold.
  - State (0,1) is unreachable. The bench asserts it never occurs.
- `SKID=0`:
  - `in_ready = ~m_valid | out_ready`, combinational.
  - Accept loads main.
  - Pop without accept clears `m_valid` and zeroes `m_data`.
- Ordering: entries leave in acceptance order. No entry is ever dropped or duplicated except by `flush` or `reset`.
- Payload is never modified. The block has no knowledge of payload fields.

## Timing
- Latency: an entry accepted at edge N appears on `out_data` after edge N, so it is visible in cycle N+1.
- Throughput: 1 entry/cycle while `out_ready=1`, for both `SKID` values.
- `SKID=1`:
  - `in_ready` is a pure flop output (`~s_valid`).
  - After `out_ready` drops, at most one further entry is absorbed before `in_ready` falls.
  - `in_ready` rises the cycle after the first pop from SKID.
- `SKID=0`: `in_ready` has a combinational path from `out_ready`.
- `out_valid` and `out_data` are always flop outputs, with no input-to-output combinational path.
- A `flush` asserted in cycle N gives `out_valid=0` in cycle N+1. A new accept in cycle N+1 appears in cycle N+2.

## Structure
- `` `DataBusBits `` and `` `DataZero `` come from `diagv2_const.vh`.
- Add `` `PipeSkidDefault `` (value 1) to `diagv2_const.vh`.
- Each stage boundary packs its fields into one `WIDTH` vector in the parent. Pack and unpack field-width macros live in `diagv2_const.vh`.
- One `generate` branch per `SKID` value. No sub-module is needed.
- Each existing stage boundary becomes one instance of this block.

## Test plan
- **Reset mid-stream:** `WIDTH=64`, `SKID=1`. Fill to SKID with `0xA`, `0xB` and `out_ready=0`, then pulse `reset`. Next cycle: `out_valid=0`, `out_data=0`, `in_ready=1`. `0xA` and `0xB` are never observed.
- **Back-to-back streaming:** `in_valid=1` and `out_ready=1` for 8 cycles with data 1..8. Output is 1..8 on consecutive cycles starting one cycle after the first accept, with no gaps.
- **Stall/skid:** stream 1,2,3 and drop `out_ready` in the cycle that 2 is accepted.
  - Next cycle `in_ready=0` and `out_data=1` holds.
  - Raise `out_ready`. Output is 1,2,3 in order and `in_ready` returns to 1 one cycle after the first pop.
- **Flush with simultaneous accept:** in SKID state holding 5,6, assert `flush` with `in_valid=1` and `in_data=7`.
  - Next cycle `out_valid=0` and `out_data=0`. 7 is never output.
  - The subsequent accept of 8 is output alone.
- **Combinational ready mode:** `SKID=0`, `WIDTH=8`.
  - With main holding `0x55`, toggle `out_ready`. `in_ready` follows it in the same cycle.
  - Accept-and-pop replaces `0x55` with `0x66` in one edge.
- **Randomised scoreboard:** `SKID` in {0,1}, `WIDTH` in {1,64,200}. Random `in_valid`, `out_ready` and `flush` (5%) for 10k cycles.
  - The FIFO model matches exactly.
  - `out_data=0` whenever `out_valid=0`.
  - (0,1) state is never entered.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants for the pipeline stage register: default payload width,
// default ready-path selection and the occupancy encoding {m_valid, s_valid}.
package pipe_skid_stage_pkg;

  localparam int DATA_BUS_BITS     = 64;
  localparam int PIPE_SKID_DEFAULT = 1;

  // Occupancy of the skid variant, encoded as {m_valid, s_valid}.
  // {0,1} cannot be reached: skid is only written while main is held.
  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_FULL  = 2'b10;
  localparam logic [1:0] OCC_SKID  = 2'b11;

endpackage

// File: rtl/pipe_skid_stage.sv
// Generic pipeline-stage register with valid/ready handshake, back-pressure
// and flush. SKID=1 adds a second slot so in_ready comes straight from a flop;
// SKID=0 is a single register whose ready is combinational on out_ready.
// out_valid/out_data are always flop outputs, and out_data is zero when idle.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_BITS,
  parameter int SKID  = PIPE_SKID_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             accept, pop;

  assign accept    = in_valid & in_ready;
  assign pop       = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

  // Main register: reset clears both valid and data so out_data reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic             s_valid_q, s_valid_d;
      logic [WIDTH-1:0] s_data_q,  s_data_d;

      // Ready depends only on the skid slot being free.
      assign in_ready = ~s_valid_q;

      // Next-state for main and skid, keyed on current occupancy.
      always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
          m_valid_d = 1'b0;
          m_data_d  = '0;
          s_valid_d = 1'b0;
          s_data_d  = '0;
        end else begin
          case ({m_valid_q, s_valid_q})
            OCC_EMPTY: begin
              if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
              end
            end
            OCC_FULL: begin
              if (accept && pop) begin
                m_data_d = in_data;
              end else if (pop) begin
                m_valid_d = 1'b0;
                m_data_d  = '0;
              end else if (accept) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
              end
            end
            OCC_SKID: begin
              if (pop) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_data_d  = '0;
              end
            end
            default: begin
            end
          endcase
        end
      end

      // Skid register: cleared on reset alongside main.
      always_ff @(posedge clk) begin
        if (reset) begin
          s_valid_q <= 1'b0;
          s_data_q  <= '0;
        end else begin
          s_valid_q <= s_valid_d;
          s_data_q  <= s_data_d;
        end
      end
    end else begin : g_comb
      // Free slot, or the held entry leaves on this same edge.
      assign in_ready = ~m_valid_q | out_ready;

      // Single-slot next-state: flush wins, then load, then drain to zero.
      always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush) begin
          m_valid_d = 1'b0;
          m_data_d  = '0;
        end else if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else if (pop) begin
          m_valid_d = 1'b0;
          m_data_d  = '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: several configurations driven by one shared
// stimulus, each checked against an in-order queue model every cycle, plus
// directed literal expectations on the 64-bit skid and 8-bit single-slot copies.
module tb_pipe_skid_stage;

  localparam int NI = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] in_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [NI-1:0] ov_all;
  logic [NI-1:0] ir_all;
  logic [255:0]  od_all [NI];

  always #5 clk = ~clk;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 64;
      1: return 8;
      2: return 1;
      3: return 200;
      4: return 1;
      5: return 64;
      default: return 200;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0, 2, 3: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int inst,
                     input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, inst, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_i
    localparam int W  = cfg_w(gi);
    localparam int SK = cfg_s(gi);

    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    logic [W-1:0] mq [$];

    pipe_skid_stage #(.WIDTH(W), .SKID(SK)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (ir),
      .in_data  (in_data[W-1:0]),
      .out_valid(ov),
      .out_ready(out_ready),
      .out_data (od)
    );

    assign ov_all[gi] = ov;
    assign ir_all[gi] = ir;
    assign od_all[gi] = 256'(od);

    // Queue model: capacity 2 with skid, 1 without; front entry is the output.
    always @(posedge clk) begin : upd
      bit pop_m;
      bit acc_m;
      if (reset || flush) begin
        mq.delete();
      end else begin
        pop_m = (mq.size() > 0) && out_ready;
        acc_m = in_valid && ((SK != 0) ? (mq.size() < 2)
                                       : (mq.size() == 0 || out_ready));
        if (pop_m) void'(mq.pop_front());
        if (acc_m) mq.push_back(in_data[W-1:0]);
      end
    end

    always @(negedge clk) begin : cmp
      logic         ev;
      logic         er;
      logic [W-1:0] ed;
      if (chk_en) begin
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : '0;
        er = (SK != 0) ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
        chk("out_valid", gi, 256'(ov), 256'(ev));
        chk("out_data",  gi, 256'(od), 256'(ed));
        chk("in_ready",  gi, 256'(ir), 256'(er));
        if (SK != 0) chk("state01", gi, 256'(ov | ir), 256'(1'b1));
      end
    end
  end

  task automatic cyc(input logic iv, input logic [255:0] d, input logic ordy,
                     input logic fl, input logic rs);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ov", 0, 256'(ov_all[0]), 256'(1'b0));
    chk("rst_od", 0, od_all[0], 256'h0);
    chk("rst_ir", 0, 256'(ir_all[0]), 256'(1'b1));
    chk("rst_ir", 1, 256'(ir_all[1]), 256'(1'b1));

    // Reset mid-stream
    cyc(1'b1, 256'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 256'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 256'h0, 1'b0, 1'b0, 1'b1);
    chk("rm_full_ir", 0, 256'(ir_all[0]), 256'(1'b0));
    chk("rm_full_od", 0, od_all[0], 256'hA);
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("rm_ov", 0, 256'(ov_all[0]), 256'(1'b0));
    chk("rm_od", 0, od_all[0], 256'h0);
    chk("rm_ir", 0, 256'(ir_all[0]), 256'(1'b1));
    repeat (2) cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 9; i++) begin
      cyc(i <= 8, 256'(i), 1'b1, 1'b0, 1'b0);
      if (i >= 2) begin
        chk("stream_od", 0, od_all[0], 256'(i - 1));
        chk("stream_od", 1, od_all[1], 256'(i - 1));
      end
    end
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("stream_end_ov", 0, 256'(ov_all[0]), 256'(1'b0));

    // Stall into skid
    cyc(1'b1, 256'h1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 256'h2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 256'h3, 1'b0, 1'b0, 1'b0);
    chk("stall_ir", 0, 256'(ir_all[0]), 256'(1'b0));
    chk("stall_od", 0, od_all[0], 256'h1);
    cyc(1'b1, 256'h3, 1'b1, 1'b0, 1'b0);
    chk("stall_hold_od", 0, od_all[0], 256'h1);
    cyc(1'b1, 256'h3, 1'b1, 1'b0, 1'b0);
    chk("stall_pop_od", 0, od_all[0], 256'h2);
    chk("stall_pop_ir", 0, 256'(ir_all[0]), 256'(1'b1));
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("stall_last_od", 0, od_all[0], 256'h3);
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("stall_end_ov", 0, 256'(ov_all[0]), 256'(1'b0));

    // Flush with simultaneous offer
    cyc(1'b1, 256'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 256'h6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 256'h7, 1'b0, 1'b1, 1'b0);
    chk("fl_pre_ir", 0, 256'(ir_all[0]), 256'(1'b0));
    chk("fl_pre_od", 0, od_all[0], 256'h5);
    cyc(1'b1, 256'h8, 1'b1, 1'b0, 1'b0);
    chk("fl_ov", 0, 256'(ov_all[0]), 256'(1'b0));
    chk("fl_od", 0, od_all[0], 256'h0);
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_new_ov", 0, 256'(ov_all[0]), 256'(1'b1));
    chk("fl_new_od", 0, od_all[0], 256'h8);
    cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_end_ov", 0, 256'(ov_all[0]), 256'(1'b0));

    // Combinational ready on the single-slot copy
    cyc(1'b1, 256'h55, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 256'h0, 1'b0, 1'b0, 1'b0);
    chk("cr_od", 1, od_all[1], 256'h55);
    chk("cr_ir_lo", 1, 256'(ir_all[1]), 256'(1'b0));
    out_ready = 1'b1;
    #1;
    chk("cr_ir_hi", 1, 256'(ir_all[1]), 256'(1'b1));
    out_ready = 1'b0;
    #1;
    chk("cr_ir_lo2", 1, 256'(ir_all[1]), 256'(1'b0));
    cyc(1'b1, 256'h66, 1'b1, 1'b0, 1'b0);
    chk("cr_ap_ir", 1, 256'(ir_all[1]), 256'(1'b1));
    chk("cr_ap_od", 1, od_all[1], 256'h55);
    cyc(1'b0, 256'h0, 1'b0, 1'b0, 1'b0);
    chk("cr_new_od", 1, od_all[1], 256'h66);
    chk("cr_new_ov", 1, 256'(ov_all[1]), 256'(1'b1));
    repeat (2) cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      cyc($urandom_range(0, 3) != 0, rnd256(),
          (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0),
          $urandom_range(0, 99) < 5, 1'b0);
    end
    repeat (4) cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
